// File: rtl/routing_header_ingress.sv
// Router-port ingress: flit FIFO plus routing-header parser that pins target_x/target_y for a whole packet.
// Flit layout on in/out (MSB..LSB): {tdata, tid, tdest, tuser, tlast}.
module routing_header_ingress #(
  parameter int DATA_WIDTH          = 32,
  parameter int ID_WIDTH            = 4,
  parameter int DEST_WIDTH          = 4,
  parameter int USER_WIDTH          = 4,
  parameter int FIFO_DEPTH          = 4,
  parameter int MAX_ROUTERS_X       = 4,
  parameter int MAX_ROUTERS_X_WIDTH = $clog2(MAX_ROUTERS_X),
  parameter int MAX_ROUTERS_Y       = 4,
  parameter int MAX_ROUTERS_Y_WIDTH = $clog2(MAX_ROUTERS_Y),
  parameter logic [ID_WIDTH-1:0] ROUTING_HEADER = ID_WIDTH'(1)
) (
  input  logic                                              clk,
  input  logic                                              rst,
  input  logic [DATA_WIDTH+ID_WIDTH+DEST_WIDTH+USER_WIDTH:0] in,
  input  logic                                              in_valid,
  output logic                                              in_ready,
  output logic [DATA_WIDTH+ID_WIDTH+DEST_WIDTH+USER_WIDTH:0] out,
  output logic                                              out_valid,
  input  logic                                              out_ready,
  output logic [MAX_ROUTERS_X_WIDTH-1:0]                    target_x,
  output logic [MAX_ROUTERS_Y_WIDTH-1:0]                    target_y,
  output logic                                              packet_active,
  output logic                                              err_drop,
  output logic                                              err_header,
  output logic [15:0]                                       drop_count
);

  localparam int FLIT_W = DATA_WIDTH + ID_WIDTH + DEST_WIDTH + USER_WIDTH + 1;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] tdata;
    logic [ID_WIDTH-1:0]   tid;
    logic [DEST_WIDTH-1:0] tdest;
    logic [USER_WIDTH-1:0] tuser;
    logic                  tlast;
  } axis_data_t;

  typedef enum logic {HEAD, BODY} state_t;

  state_t state, state_nxt;

  logic [FLIT_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [PTR_W:0]    count;
  logic              full, empty, push, pop, latch, is_hdr;
  axis_data_t        head;

  logic [MAX_ROUTERS_X_WIDTH-1:0] tx_q, hdr_x;
  logic [MAX_ROUTERS_Y_WIDTH-1:0] ty_q, hdr_y;

  assign full     = (count == (PTR_W+1)'(FIFO_DEPTH));
  assign empty    = (count == '0);
  assign in_ready = !full;
  assign push     = in_valid && in_ready;
  assign head     = mem[rd_ptr];
  assign is_hdr   = (head.tid == ROUTING_HEADER);
  assign hdr_x    = head.tdata[MAX_ROUTERS_X_WIDTH-1:0];
  assign hdr_y    = head.tdata[MAX_ROUTERS_X_WIDTH +: MAX_ROUTERS_Y_WIDTH];
  assign packet_active = (state == BODY);

  // Storage carries no reset; occupancy is owned by the pointers/count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      state      <= HEAD;
      tx_q       <= '0;
      ty_q       <= '0;
      drop_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
      state <= state_nxt;
      if (latch) begin
        tx_q <= hdr_x;
        ty_q <= hdr_y;
      end
      if (err_drop && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
    end
  end

  always_comb begin
    state_nxt  = state;
    out        = '0;
    out_valid  = 1'b0;
    pop        = 1'b0;
    latch      = 1'b0;
    err_drop   = 1'b0;
    err_header = 1'b0;
    target_x   = tx_q;
    target_y   = ty_q;
    case (state)
      HEAD: begin
        if (!empty) begin
          if (is_hdr) begin
            // Target is decoded straight off the head so it lines up with the header flit.
            out       = head;
            out_valid = 1'b1;
            target_x  = hdr_x;
            target_y  = hdr_y;
            if (out_ready) begin
              pop   = 1'b1;
              latch = 1'b1;
              if (!head.tlast) state_nxt = BODY;
            end
          end else begin
            // Stray flit outside a packet: discard without waiting on downstream.
            pop      = 1'b1;
            err_drop = 1'b1;
          end
        end
      end
      BODY: begin
        if (!empty) begin
          out       = head;
          out_valid = 1'b1;
          if (out_ready) begin
            pop        = 1'b1;
            err_header = is_hdr;
            if (head.tlast) state_nxt = HEAD;
          end
        end
      end
      default: state_nxt = HEAD;
    endcase
  end

endmodule

// File: tb/tb_routing_header_ingress.sv
// Bench for routing_header_ingress: queue-based packet model compared every cycle, directed scenarios plus random traffic.
module tb_routing_header_ingress;

  localparam int FW    = 45;
  localparam int DEPTH = 4;
  localparam logic [3:0] HDR = 4'h1;

  logic          clk = 1'b0;
  logic          rst;
  logic [FW-1:0] in_flit;
  logic          in_valid;
  logic          in_ready;
  logic [FW-1:0] out_flit;
  logic          out_valid;
  logic          out_ready;
  logic [1:0]    target_x, target_y;
  logic          packet_active, err_drop, err_header;
  logic [15:0]   drop_count;

  int total = 0;
  int bad   = 0;

  routing_header_ingress dut (
    .clk(clk), .rst(rst),
    .in(in_flit), .in_valid(in_valid), .in_ready(in_ready),
    .out(out_flit), .out_valid(out_valid), .out_ready(out_ready),
    .target_x(target_x), .target_y(target_y),
    .packet_active(packet_active), .err_drop(err_drop), .err_header(err_header),
    .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  // Reference model: buffered flits, whether a packet is open, latched target, drop tally.
  logic [FW-1:0] mq [$];
  logic          m_act;
  logic [1:0]    m_tx, m_ty;
  logic [15:0]   m_dc;
  logic          m_hs, m_drop;

  function automatic logic [FW-1:0] mk(input logic [31:0] d, input logic [3:0] tid, input logic last);
    logic [3:0] dst, usr;
    dst = 4'($urandom_range(0, 15));
    usr = 4'($urandom_range(0, 15));
    return {d, tid, dst, usr, last};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_act = 1'b0;
    m_tx  = '0;
    m_ty  = '0;
    m_dc  = '0;
  endtask

  task automatic model_check();
    logic          e_ov, e_drop, e_eh, hdr;
    logic [FW-1:0] e_out, h;
    logic [1:0]    e_tx, e_ty;
    e_ov = 1'b0; e_out = '0; e_drop = 1'b0; e_eh = 1'b0; hdr = 1'b0;
    e_tx = m_tx; e_ty = m_ty; h = '0;
    if (mq.size() > 0) begin
      h   = mq[0];
      hdr = (h[12:9] == HDR);
      if (!m_act) begin
        if (hdr) begin
          e_ov = 1'b1; e_out = h;
          e_tx = h[14:13]; e_ty = h[16:15];
        end else begin
          e_drop = 1'b1;
        end
      end else begin
        e_ov = 1'b1; e_out = h;
      end
    end
    m_hs   = e_ov && out_ready;
    m_drop = e_drop;
    e_eh   = m_act && m_hs && hdr;
    chk("in_ready",      64'(in_ready),      64'(mq.size() < DEPTH));
    chk("out_valid",     64'(out_valid),     64'(e_ov));
    chk("out",           64'(out_flit),      64'(e_out));
    chk("target_x",      64'(target_x),      64'(e_tx));
    chk("target_y",      64'(target_y),      64'(e_ty));
    chk("packet_active", 64'(packet_active), 64'(m_act));
    chk("err_drop",      64'(err_drop),      64'(e_drop));
    chk("err_header",    64'(err_header),    64'(e_eh));
    chk("drop_count",    64'(drop_count),    64'(m_dc));
  endtask

  task automatic model_update();
    logic          do_push;
    logic [FW-1:0] h;
    if (rst) begin
      model_reset();
    end else begin
      do_push = in_valid && (mq.size() < DEPTH);
      if (m_hs || m_drop) begin
        h = mq.pop_front();
        if (m_hs && !m_act && h[12:9] == HDR) begin
          m_tx  = h[14:13];
          m_ty  = h[16:15];
          m_act = !h[0];
        end else if (m_hs && m_act && h[0]) begin
          m_act = 1'b0;
        end
        if (m_drop && m_dc != 16'hFFFF) m_dc = m_dc + 16'd1;
      end
      if (do_push) mq.push_back(in_flit);
    end
  endtask

  task automatic drive(input logic r, input logic iv, input logic [FW-1:0] f, input logic ordy);
    rst = r; in_valid = iv; in_flit = f; out_ready = ordy;
    #4;
    model_check();
  endtask

  task automatic adv();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic step(input logic r, input logic iv, input logic [FW-1:0] f, input logic ordy);
    drive(r, iv, f, ordy);
    adv();
  endtask

  logic [FW-1:0] h9, d1, d2l, hf, h0, h6, hmid, stray, held;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_flit = '0; out_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    drive(1'b0, 1'b0, '0, 1'b1);
    chk("rst_in_ready",   64'(in_ready),   64'd1);
    chk("rst_out_valid",  64'(out_valid),  64'd0);
    chk("rst_drop_count", 64'(drop_count), 64'd0);
    adv();

    // Basic packet, no backpressure
    h9  = mk(32'h0000_0009, HDR, 1'b0);
    d1  = mk(32'hDEAD_0001, 4'h2, 1'b0);
    d2l = mk(32'hDEAD_0002, 4'h3, 1'b1);
    step(1'b0, 1'b1, h9, 1'b1);
    drive(1'b0, 1'b1, d1, 1'b1);
    chk("t1_hdr_valid", 64'(out_valid), 64'd1);
    chk("t1_hdr_x",     64'(target_x),  64'd1);
    chk("t1_hdr_y",     64'(target_y),  64'd2);
    chk("t1_hdr_pa",    64'(packet_active), 64'd0);
    adv();
    drive(1'b0, 1'b1, d2l, 1'b1);
    chk("t1_d1_pa", 64'(packet_active), 64'd1);
    chk("t1_d1_x",  64'(target_x), 64'd1);
    adv();
    drive(1'b0, 1'b0, '0, 1'b1);
    chk("t1_d2_pa",   64'(packet_active), 64'd1);
    chk("t1_d2_last", 64'(out_flit[0]), 64'd1);
    chk("t1_d2_y",    64'(target_y), 64'd2);
    adv();
    drive(1'b0, 1'b0, '0, 1'b1);
    chk("t1_end_pa", 64'(packet_active), 64'd0);
    adv();

    // Backpressure: fill the FIFO while downstream stalls
    step(1'b0, 1'b1, h9, 1'b0);
    step(1'b0, 1'b1, d1, 1'b0);
    step(1'b0, 1'b1, d2l, 1'b0);
    step(1'b0, 1'b1, h9, 1'b0);
    drive(1'b0, 1'b1, d1, 1'b0);
    chk("t2_full_ready", 64'(in_ready), 64'd0);
    chk("t2_held_out",   64'(out_flit), 64'(h9));
    held = out_flit;
    adv();
    drive(1'b0, 1'b0, '0, 1'b0);
    chk("t2_still_held", 64'(out_flit), 64'(held));
    adv();
    repeat (6) step(1'b0, 1'b0, '0, 1'b1);
    step(1'b0, 1'b1, d2l, 1'b1);
    repeat (2) step(1'b0, 1'b0, '0, 1'b1);

    // Stray flit in HEAD is dropped, following header forwarded
    step(1'b1, 1'b0, '0, 1'b1);
    stray = mk(32'h1234_5678, 4'h5, 1'b0);
    hf    = mk(32'h0000_0009, HDR, 1'b1);
    step(1'b0, 1'b1, stray, 1'b1);
    drive(1'b0, 1'b1, hf, 1'b1);
    chk("t3_err_drop", 64'(err_drop),  64'd1);
    chk("t3_no_valid", 64'(out_valid), 64'd0);
    adv();
    drive(1'b0, 1'b0, '0, 1'b1);
    chk("t3_drop_count", 64'(drop_count), 64'd1);
    chk("t3_hdr_fwd",    64'(out_valid),  64'd1);
    chk("t3_drop_once",  64'(err_drop),   64'd0);
    adv();

    // Single-flit packets back to back
    hf = mk(32'h0000_000F, HDR, 1'b1);
    h0 = mk(32'h0000_0000, HDR, 1'b1);
    step(1'b0, 1'b1, hf, 1'b1);
    drive(1'b0, 1'b1, h0, 1'b1);
    chk("t4_x3", 64'(target_x), 64'd3);
    chk("t4_y3", 64'(target_y), 64'd3);
    chk("t4_pa", 64'(packet_active), 64'd0);
    adv();
    drive(1'b0, 1'b0, '0, 1'b1);
    chk("t4_x0", 64'(target_x), 64'd0);
    chk("t4_y0", 64'(target_y), 64'd0);
    chk("t4_pa2", 64'(packet_active), 64'd0);
    adv();

    // Header inside a packet is data; target is not updated
    h6   = mk(32'h0000_0006, HDR, 1'b0);
    hmid = mk(32'h0000_000F, HDR, 1'b0);
    step(1'b0, 1'b1, h6, 1'b1);
    drive(1'b0, 1'b1, d1, 1'b1);
    chk("t5_x2", 64'(target_x), 64'd2);
    chk("t5_y1", 64'(target_y), 64'd1);
    adv();
    step(1'b0, 1'b1, hmid, 1'b1);
    drive(1'b0, 1'b1, d2l, 1'b1);
    chk("t5_err_header", 64'(err_header), 64'd1);
    chk("t5_keep_x",     64'(target_x),   64'd2);
    chk("t5_keep_y",     64'(target_y),   64'd1);
    adv();
    drive(1'b0, 1'b0, '0, 1'b1);
    chk("t5_eh_once", 64'(err_header), 64'd0);
    chk("t5_last_x",  64'(target_x),   64'd2);
    adv();
    step(1'b0, 1'b0, '0, 1'b1);

    // Reset mid-packet with three flits buffered
    step(1'b0, 1'b1, h9, 1'b1);
    step(1'b0, 1'b1, d1, 1'b1);
    step(1'b0, 1'b1, d1, 1'b0);
    step(1'b0, 1'b1, d1, 1'b0);
    drive(1'b1, 1'b0, '0, 1'b0);
    chk("t6_pre_pa", 64'(packet_active), 64'd1);
    adv();
    drive(1'b0, 1'b0, '0, 1'b0);
    chk("t6_valid", 64'(out_valid),     64'd0);
    chk("t6_pa",    64'(packet_active), 64'd0);
    chk("t6_x",     64'(target_x),      64'd0);
    chk("t6_y",     64'(target_y),      64'd0);
    chk("t6_dc",    64'(drop_count),    64'd0);
    chk("t6_ready", 64'(in_ready),      64'd1);
    adv();

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      logic [3:0]  tid;
      logic        last, r;
      tid  = ($urandom_range(0, 9) < 4) ? HDR : 4'($urandom_range(0, 15));
      last = ($urandom_range(0, 9) < 3);
      r    = ($urandom_range(0, 499) == 0);
      step(r, $urandom_range(0, 9) < 7, mk($urandom, tid, last), $urandom_range(0, 9) < 6);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
